// File: rtl/fetch_controller_pkg.sv
// Shared ISA definitions for the fetch path: word width, boot address,
// fetch FSM states and the {pc, inst} entry carried through the prefetch buffer.
package fetch_controller_pkg;

  localparam int WORD = 32;
  localparam logic [WORD-1:0] RESET_PC_DEFAULT = 32'h0040_0000;

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [WORD-1:0] pc;
    logic [WORD-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch buffer of {pc, inst} entries with push, pop and flush; head readable
// combinationally, 1-cycle write latency; push on a full buffer only lands with a pop.
module fetch_fifo
  import fetch_controller_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  fetch_entry_t push_entry,
  input  logic         pop,
  input  logic         flush,
  output fetch_entry_t head,
  output logic [CW-1:0] occupancy
);

  fetch_entry_t mem [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;
  logic push_ok, pop_ok;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // A full buffer still accepts a push when the head leaves in the same cycle.
  assign pop_ok  = pop && (count != '0);
  assign push_ok = push && ((count != CW'(DEPTH)) || pop_ok);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= ptr_inc(wr_ptr);
      if (pop_ok)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok && !flush) mem[wr_ptr] <= push_entry;
  end

  assign head      = mem[rd_ptr];
  assign occupancy = count;

endmodule

// File: rtl/fetch_controller.sv
// Instruction fetch: issues word reads, buffers responses and hands them to decode.
// Request-to-out_valid latency 1 cycle; stalls issue when decode backpressure would overflow the buffer.
module fetch_controller
  import fetch_controller_pkg::*;
#(
  parameter logic [WORD-1:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [WORD-1:0] imem_addr,
  input  logic [WORD-1:0] imem_data,
  input  logic            redirect,
  input  logic [WORD-1:0] redirect_pc,
  input  logic            halt,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [WORD-1:0] out_inst,
  output logic [WORD-1:0] out_pc
);

  localparam int CW = $clog2(DEPTH + 1);

  fetch_state_t state, state_nxt;
  logic [WORD-1:0] fetch_pc, inflight_pc;
  logic inflight, issue, pop, push, fifo_pop, bypass, room;
  logic [CW-1:0] occupancy;
  logic [CW:0]   vis_after;
  fetch_entry_t  head, arriving;

  assign arriving = '{pc: inflight_pc, inst: imem_data};

  // The arriving response counts as occupied: decode may take it straight off the bus.
  assign bypass    = (occupancy == '0);
  assign out_valid = !bypass || inflight;
  assign pop       = out_valid && out_ready && !redirect;
  assign fifo_pop  = pop && !bypass;
  assign push      = inflight && !redirect && !(pop && bypass);
  assign vis_after = {1'b0, occupancy} + {{CW{1'b0}}, inflight} - {{CW{1'b0}}, pop};
  assign room      = vis_after < (CW + 1)'(DEPTH);

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push),
    .push_entry (arriving),
    .pop        (fifo_pop),
    .flush      (redirect),
    .head       (head),
    .occupancy  (occupancy)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= BOOT;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    case (state)
      BOOT:    state_nxt = RUN;
      RUN: begin
        if (halt) state_nxt = HALTED;
        issue = !halt && !redirect && room;
      end
      HALTED:  if (!halt) state_nxt = RUN;
      default: state_nxt = BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc    <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
    end else begin
      inflight <= issue;
      if (issue) inflight_pc <= fetch_pc;
      if (redirect)   fetch_pc <= redirect_pc & 32'hFFFF_FFFC;
      else if (issue) fetch_pc <= fetch_pc + 32'd4;
    end
  end

  assign imem_req  = issue;
  assign imem_addr = fetch_pc;

  always_comb begin
    out_inst = '0;
    out_pc   = '0;
    if (!bypass) begin
      out_inst = head.inst;
      out_pc   = head.pc;
    end else if (inflight) begin
      out_inst = imem_data;
      out_pc   = inflight_pc;
    end
  end

endmodule
